// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencing FSM stepping one RV32I instruction
// (lw, sw, R-type, addi, beq) through the shared multi-cycle datapath.
module multicycle_controller #(
    parameter int OP_WIDTH = 7,
    parameter int WIDTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] op,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                ir_write,
    output logic                mem_write,
    output logic                reg_write,
    output logic [WIDTH-1:0]    result_src,
    output logic [WIDTH-1:0]    alu_src_a,
    output logic [WIDTH-1:0]    alu_src_b,
    output logic [WIDTH-1:0]    imm_src,
    output logic [WIDTH-1:0]    alu_op,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [3:0]          state_o
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        EXEC_I    = 4'd8,
        BEQ       = 4'd9
    } state_e;

    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RT   = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(7'b1100011);

    state_e state_q, state_d;

    logic is_lw, is_sw, is_rt, is_addi, is_beq, is_legal;
    logic pc_write_s, ir_write_s, mem_write_s, reg_write_s, illegal_s, done_s;

    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_rt    = (op == OP_RT);
    assign is_addi  = (op == OP_ADDI);
    assign is_beq   = (op == OP_BEQ);
    assign is_legal = is_lw | is_sw | is_rt | is_addi | is_beq;

    assign imm_src = is_sw ? WIDTH'(1) : is_beq ? WIDTH'(2) : WIDTH'(0);

    always_ff @(posedge clk) begin
        state_q <= rst ? FETCH : state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE:    state_d = (is_lw | is_sw) ? MEM_ADR :
                                 is_rt           ? EXEC_R  :
                                 is_addi         ? EXEC_I  :
                                 is_beq          ? BEQ     : FETCH;
            MEM_ADR:   state_d = is_lw ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            EXEC_R:    state_d = ALU_WB;
            EXEC_I:    state_d = ALU_WB;
            default:   state_d = FETCH;
        endcase
    end

    // Datapath selects follow the state alone; enables are gated by rst below.
    always_comb begin
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        result_src  = WIDTH'(0);
        alu_src_a   = WIDTH'(0);
        alu_src_b   = WIDTH'(0);
        alu_op      = WIDTH'(0);
        illegal_s   = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = WIDTH'(2);
                result_src = WIDTH'(2);
                pc_write_s = mem_ready;
                ir_write_s = mem_ready;
            end
            DECODE: begin
                alu_src_a = WIDTH'(1);
                alu_src_b = WIDTH'(1);
                illegal_s = ~is_legal;
                done_s    = ~is_legal;
            end
            MEM_ADR: begin
                alu_src_a = WIDTH'(2);
                alu_src_b = WIDTH'(1);
            end
            MEM_READ: adr_src = 1'b1;
            MEM_WB: begin
                result_src  = WIDTH'(1);
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            MEM_WRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
                done_s      = mem_ready;
            end
            EXEC_R: begin
                alu_src_a = WIDTH'(2);
                alu_op    = WIDTH'(2);
            end
            ALU_WB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            EXEC_I: begin
                alu_src_a = WIDTH'(2);
                alu_src_b = WIDTH'(1);
                alu_op    = WIDTH'(2);
            end
            BEQ: begin
                alu_src_a  = WIDTH'(2);
                alu_op     = WIDTH'(1);
                pc_write_s = zero;
                done_s     = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write   = ~rst & pc_write_s;
    assign ir_write   = ~rst & ir_write_s;
    assign mem_write  = ~rst & mem_write_s;
    assign reg_write  = ~rst & reg_write_s;
    assign illegal_op = ~rst & illegal_s;
    assign instr_done = ~rst & done_s;
    assign state_o    = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream with stalls; expected per-cycle
// outputs are queued by the driver and compared by an independent monitor.
module tb_multicycle_controller;
    logic       clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] op = 7'd0;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_op, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
    logic [3:0] state_o;

    multicycle_controller #(.OP_WIDTH(7), .WIDTH(2)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_op(alu_op), .illegal_op(illegal_op), .instr_done(instr_done),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] AI = 7'b0010011, BQ = 7'b1100011;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, adr, irw, memw, regw;
        logic [1:0] res, sa, sb, imm, aop;
        logic ill, done;
    } out_t;

    out_t exp_q[$], msk_q[$];
    int   errors = 0, checks = 0, done_seen = 0, done_exp = 0;

    function automatic out_t model(input int ph, input logic [6:0] o, input logic z, input logic mr);
        out_t e = '0;
        e.st  = 4'(ph);
        e.imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : 2'd0;
        case (ph)
            0: begin e.sb = 2; e.res = 2; e.pcw = mr; e.irw = mr; end
            1: begin
                e.sa = 1; e.sb = 1;
                e.ill = !(o inside {LW, SW, RT, AI, BQ});
                e.done = e.ill;
            end
            2: begin e.sa = 2; e.sb = 1; end
            3: e.adr = 1;
            4: begin e.res = 1; e.regw = 1; e.done = 1; end
            5: begin e.adr = 1; e.memw = 1; e.done = mr; end
            6: begin e.sa = 2; e.aop = 2; end
            7: begin e.regw = 1; e.done = 1; end
            8: begin e.sa = 2; e.sb = 1; e.aop = 2; end
            9: begin e.sa = 2; e.aop = 1; e.pcw = z; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic out_t rst_mask();
        out_t m = '0;
        m.st = '1; m.pcw = 1; m.irw = 1; m.memw = 1; m.regw = 1; m.ill = 1; m.done = 1;
        return m;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input logic [6:0] o, input int ph, input logic mr, input logic z, input logic r);
        @(posedge clk);
        #1;
        rst = r; op = o; mem_ready = mr; zero = z;
        exp_q.push_back(r ? out_t'('0) : model(ph, o, z, mr));
        msk_q.push_back(r ? rst_mask() : out_t'('1));
    endtask

    task automatic run(input logic [6:0] o, input int fs, input int ms, input logic bz);
        repeat (fs) cyc(o, 0, 1'b0, rb(), 1'b0);
        cyc(o, 0, 1'b1, rb(), 1'b0);
        cyc(o, 1, rb(), rb(), 1'b0);
        if (o == LW || o == SW) begin
            cyc(o, 2, rb(), rb(), 1'b0);
            repeat (ms) cyc(o, (o == LW) ? 3 : 5, 1'b0, rb(), 1'b0);
            cyc(o, (o == LW) ? 3 : 5, 1'b1, rb(), 1'b0);
            if (o == LW) cyc(o, 4, rb(), rb(), 1'b0);
        end else if (o == RT) begin
            cyc(o, 6, rb(), rb(), 1'b0);
            cyc(o, 7, rb(), rb(), 1'b0);
        end else if (o == AI) begin
            cyc(o, 8, rb(), rb(), 1'b0);
            cyc(o, 7, rb(), rb(), 1'b0);
        end else if (o == BQ) begin
            cyc(o, 9, rb(), bz, 1'b0);
        end
        done_exp++;
    endtask

    initial begin : monitor
        out_t e, m, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                a = {state_o, pc_write, adr_src, ir_write, mem_write, reg_write,
                     result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal_op, instr_done};
                checks++;
                if ((a & m) !== (e & m)) begin
                    errors++;
                    $display("FAIL cycle_check #%0d: got %h required %h (mask %h)", checks, a, e, m);
                end
                if (instr_done === 1'b1) done_seen++;
            end
        end
    end

    initial begin : driver
        logic [6:0] o;
        logic [6:0] kinds [6];
        kinds = '{LW, SW, RT, AI, BQ, 7'b1111111};
        cyc(LW, 0, 1'b0, 1'b0, 1'b1);
        cyc(LW, 0, 1'b0, 1'b0, 1'b1);
        run(LW, 0, 0, 1'b0);
        run(SW, 0, 2, 1'b0);
        run(BQ, 0, 0, 1'b1);
        run(BQ, 0, 0, 1'b0);
        run(AI, 0, 0, 1'b0);
        run(RT, 0, 0, 1'b0);
        run(7'b1111111, 0, 0, 1'b0);
        cyc(LW, 0, 1'b1, 1'b0, 1'b0);
        cyc(LW, 1, 1'b1, 1'b0, 1'b0);
        cyc(LW, 2, 1'b1, 1'b0, 1'b0);
        cyc(LW, 3, 1'b0, 1'b0, 1'b0);
        cyc(LW, 3, 1'b0, 1'b0, 1'b1);
        cyc(LW, 3, 1'b1, 1'b0, 1'b1);
        run(SW, 0, 0, 1'b0);
        run(LW, 2, 3, 1'b0);
        for (int i = 0; i < 300; i++) begin
            o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : kinds[$urandom_range(0, 5)];
            run(o, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, rb());
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL instr_done_count: got %0d required %0d", done_seen, done_exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I datapath. It replaces single-cycle control with a Moore state machine that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives the shared ALU/memory/register-file datapath one phase at a time. It supports lw, sw, R-type, addi and beq, and handshakes with a single shared instruction/data memory through `mem_ready`.

## Interface
- OP_WIDTH, 7, opcode width
- WIDTH, 2, width of imm_src, alu_op, alu_src_a, alu_src_b, result_src
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  OP_WIDTH  opcode from instruction register; stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  instruction register (and old-PC) enable
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- result_src  out  WIDTH  00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a  out  WIDTH  00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  WIDTH  00 = rs2, 01 = immediate, 10 = constant 4
- imm_src  out  WIDTH  00 = I, 01 = S, 10 = B (combinational from op)
- alu_op  out  WIDTH  00 = add, 01 = subtract/compare, 10 = funct-decoded
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- instr_done  out  1  high in the final cycle of each instruction
- state_o  out  4  current state encoding, for debug

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_READ = 3, MEM_WB = 4
  - MEM_WRITE = 5, EXEC_R = 6, ALU_WB = 7, EXEC_I = 8, BEQ = 9
  - Encodings 10–15 are unreachable; if entered, go to FETCH next cycle.
- Outputs not listed for a state are 0.
- FETCH:
  - adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - alu_src_a = 01, alu_src_b = 01, alu_op = 00 (computes the branch target).
  - Next state by op:
    - 0000011 (lw) or 0100011 (sw) → MEM_ADR
    - 0110011 (R-type) → EXEC_R
    - 0010011 (addi) → EXEC_I
    - 1100011 (beq) → BEQ
    - any other opcode → FETCH, with illegal_op = 1 and instr_done = 1
- MEM_ADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Go to MEM_READ if op = lw, else MEM_WRITE.
- MEM_READ: adr_src = 1, result_src = 00. Hold while mem_ready = 0, then go to MEM_WB.
- MEM_WB: result_src = 01, reg_write = 1, instr_done = 1. Next state FETCH.
- MEM_WRITE:
  - adr_src = 1, result_src = 00, mem_write = 1; mem_write stays high until mem_ready.
  - On mem_ready: instr_done = 1, next state FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next state ALU_WB.
- EXEC_I: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next state ALU_WB.
- ALU_WB: result_src = 00, reg_write = 1, instr_done = 1. Next state FETCH.
- BEQ:
  - alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00.
  - pc_write = zero, instr_done = 1. Next state FETCH.
- imm_src:
  - 01 for sw, 10 for beq, 00 for all other opcodes.
  - Valid in every state, since it depends only on op.

## Timing
- Reset:
  - rst high at a rising edge loads FETCH.
  - While rst is high, pc_write, ir_write, mem_write, reg_write, illegal_op and instr_done are forced to 0, and state_o = 0.
  - Reset mid-instruction abandons the instruction; no writes are issued.
- Outputs are combinational from state, except:
  - pc_write, which depends on mem_ready in FETCH and on zero in BEQ;
  - ir_write and the MEM_WRITE exit, which depend on mem_ready.
- Cycle counts with mem_ready tied to 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs hold their values during the stall.
- Every retired or rejected instruction produces exactly one instr_done pulse.
- Write enables (pc_write, ir_write, mem_write, reg_write) never assert in DECODE, MEM_ADR, EXEC_R or EXEC_I.

## Test plan
- Reset: assert rst for 2 cycles mid-MEM_READ → state_o = 0 and all enables 0; after release, first cycle has ir_write = pc_write = 1 (mem_ready = 1).
- lw (op = 0000011), mem_ready = 1 → state_o sequence 0, 1, 2, 3, 4; reg_write only in state 4 with result_src = 01; instr_done asserts in the 5th cycle.
- sw (op = 0100011), mem_ready low for 2 cycles in MEM_WRITE → sequence 0, 1, 2, 5, 5, 5; mem_write high for all 3 cycles in state 5; imm_src = 01; reg_write never asserts.
- beq (op = 1100011), once with zero = 1 and once with zero = 0 → sequence 0, 1, 9; pc_write in BEQ equals zero; imm_src = 10; alu_op = 01.
- addi then R-type back-to-back → 0, 1, 8, 7 then 0, 1, 6, 7; alu_src_b = 01 in EXEC_I and 00 in EXEC_R; exactly two instr_done pulses.
- Illegal op = 1111111 → 0, 1, 0; illegal_op and instr_done pulse for one cycle in DECODE; no write enables assert.
